// File: rtl/segfx_pkg.sv
// Shared constants for the seven-segment effect sequencer: segment bits, mode codes,
// FSM states and per-mode frame counts.
package segfx_pkg;

   localparam int SEG_W   = 7;
   localparam int FRAME_W = 3;
   localparam int DIV_W   = 3;

   localparam logic [SEG_W-1:0] SEG_A = 7'h01;
   localparam logic [SEG_W-1:0] SEG_B = 7'h02;
   localparam logic [SEG_W-1:0] SEG_C = 7'h04;
   localparam logic [SEG_W-1:0] SEG_D = 7'h08;
   localparam logic [SEG_W-1:0] SEG_E = 7'h10;
   localparam logic [SEG_W-1:0] SEG_F = 7'h20;
   localparam logic [SEG_W-1:0] SEG_G = 7'h40;

   localparam logic [1:0] MODE_SPIN  = 2'd0;
   localparam logic [1:0] MODE_CHASE = 2'd1;
   localparam logic [1:0] MODE_FILL  = 2'd2;
   localparam logic [1:0] MODE_BLINK = 2'd3;

   localparam logic [3:0] LEN_SPIN  = 4'd6;
   localparam logic [3:0] LEN_CHASE = 4'd8;
   localparam logic [3:0] LEN_FILL  = 4'd8;
   localparam logic [3:0] LEN_BLINK = 4'd2;

   typedef enum logic [1:0] {
      S_BLANK = 2'd0,
      S_RUN   = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   // Index of the last frame of a mode; lengths up to 8 need 4 bits, indices only 3.
   function automatic logic [FRAME_W-1:0] last_frame(input logic [1:0] mode);
      logic [3:0] len;
      logic [3:0] len_m1;
      case (mode)
         MODE_SPIN:  len = LEN_SPIN;
         MODE_CHASE: len = LEN_CHASE;
         MODE_FILL:  len = LEN_FILL;
         default:    len = LEN_BLINK;
      endcase
      len_m1 = len - 4'd1;
      return len_m1[FRAME_W-1:0];
   endfunction

endpackage

// File: rtl/segfx_pattern_rom.sv
// Combinational frame table: (mode, frame index) -> {g,f,e,d,c,b,a}.
// Frames past the end of a mode's table read as blank.
module segfx_pattern_rom
   import segfx_pkg::*;
(
   input  logic [1:0]         mode,
   input  logic [FRAME_W-1:0] frame,
   output logic [SEG_W-1:0]   pattern
);

   always_comb begin
      pattern = '0;
      case (mode)
         MODE_SPIN: begin
            case (frame)
               3'd0:    pattern = SEG_A;
               3'd1:    pattern = SEG_B;
               3'd2:    pattern = SEG_C;
               3'd3:    pattern = SEG_D;
               3'd4:    pattern = SEG_E;
               3'd5:    pattern = SEG_F;
               default: pattern = '0;
            endcase
         end
         MODE_CHASE: begin
            // Figure-eight path: the middle bar is crossed twice per lap.
            case (frame)
               3'd0:    pattern = SEG_A;
               3'd1:    pattern = SEG_B;
               3'd2:    pattern = SEG_G;
               3'd3:    pattern = SEG_E;
               3'd4:    pattern = SEG_D;
               3'd5:    pattern = SEG_C;
               3'd6:    pattern = SEG_G;
               default: pattern = SEG_F;
            endcase
         end
         MODE_FILL: begin
            case (frame)
               3'd0:    pattern = SEG_A;
               3'd1:    pattern = SEG_A | SEG_B;
               3'd2:    pattern = SEG_A | SEG_B | SEG_C;
               3'd3:    pattern = SEG_A | SEG_B | SEG_C | SEG_D;
               3'd4:    pattern = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E;
               3'd5:    pattern = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
               3'd6:    pattern = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
               default: pattern = '0;
            endcase
         end
         default: begin
            case (frame)
               3'd0:    pattern = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
               default: pattern = '0;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/segfx_sequencer.sv
// Turns step-count changes into animated seven-segment frames with pause and mode control.
// Define SEGFX_DP_HEARTBEAT_EN to add o_dp, which toggles on every upstream count wrap.
module segfx_sequencer
   import segfx_pkg::*;
#(
   parameter int COUNT_W  = 3,
   parameter int STEP_DIV = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [COUNT_W-1:0] i_count,
   input  logic [1:0]         i_mode,
   input  logic               i_pause,
   output logic [SEG_W-1:0]   o_segments,
   output logic               o_wrap
`ifdef SEGFX_DP_HEARTBEAT_EN
   ,
   output logic               o_dp
`endif
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   state_t               r_state, state_next;
   logic [FRAME_W-1:0]   r_frame, frame_next;
   logic [DIV_W-1:0]     r_div, div_next;
   logic                 r_wrap, wrap_next;
   logic [COUNT_W-1:0]   r_count_q;
   logic [1:0]           r_mode_q;
   logic                 step, mode_chg, div_en, div_last, advance;
   logic [SEG_W-1:0]     rom_pattern;

   assign step     = (i_count != r_count_q);
   assign mode_chg = (i_mode != r_mode_q);
   // Pause and the hold state both freeze the divider, so steps there are simply lost.
   assign div_en   = step && !i_pause && (r_state != S_HOLD);
   assign div_last = (r_div == DIV_LAST);
   assign advance  = div_en && div_last;

   always_comb begin
      state_next = r_state;
      frame_next = r_frame;
      div_next   = r_div;
      wrap_next  = 1'b0;
      if (mode_chg) begin
         state_next = S_BLANK;
         frame_next = '0;
         div_next   = '0;
      end else begin
         if (div_en) begin
            div_next = div_last ? '0 : r_div + 1'b1;
         end
         case (r_state)
            S_BLANK: begin
               if (advance) begin
                  state_next = S_RUN;
                  frame_next = '0;
               end
            end
            S_RUN: begin
               if (i_pause) begin
                  state_next = S_HOLD;
               end else if (advance) begin
                  if (r_frame == last_frame(r_mode_q)) begin
                     frame_next = '0;
                     wrap_next  = 1'b1;
                  end else begin
                     frame_next = r_frame + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (!i_pause) begin
                  state_next = S_RUN;
               end
            end
            default: state_next = S_BLANK;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_BLANK;
         r_frame   <= '0;
         r_div     <= '0;
         r_wrap    <= 1'b0;
         r_count_q <= '0;
         r_mode_q  <= i_mode;
      end else begin
         r_state   <= state_next;
         r_frame   <= frame_next;
         r_div     <= div_next;
         r_wrap    <= wrap_next;
         r_count_q <= i_count;
         r_mode_q  <= i_mode;
      end
   end

   segfx_pattern_rom u_rom (
      .mode    (r_mode_q),
      .frame   (r_frame),
      .pattern (rom_pattern)
   );

   // Display decodes registered state only, so it follows the step edge by one clock.
   assign o_segments = (r_state == S_BLANK) ? '0 : rom_pattern;
   assign o_wrap     = r_wrap;

`ifdef SEGFX_DP_HEARTBEAT_EN
   logic r_dp;
   logic count_wrap;

   assign count_wrap = step && (r_count_q == '1) && (i_count == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_dp <= 1'b0;
      end else if (count_wrap) begin
         r_dp <= ~r_dp;
      end
   end

   assign o_dp = r_dp;
`endif

endmodule
